mult_div_ctrl: RTL and testbench

MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

---
 rtl/mult_div_ctrl.sv | 142 ++++++++++++++
 tb/tb_mult_div_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_ctrl
// Purpose  : Iterative signed 32x32 multiply / 32/32 divide into HI/LO (34 edges).
// Option   : MULT_DIV_DIVZERO_TRAP_EN - divide by zero completes at once, flags div_zero.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_ctrl (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_zero
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_RUN  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t      state_q;
   logic        op_q;
   logic [31:0] a_q, b_q, mcand_q;
   logic [63:0] prod_q;
   logic [4:0]  cnt_q;
   logic        busy_q, done_q, dz_q;
   logic [31:0] hi_q, lo_q;

   logic [32:0] sum_d, shifted_d;
   logic [31:0] diff_d, a_mag, b_mag, fix_hi, fix_lo, q_neg, r_neg;
   logic [63:0] prod_d, prod_neg;
   logic        ge_d, sign_res, trap;

`ifdef MULT_DIV_DIVZERO_TRAP_EN
   assign trap = op & (b == 32'd0);
`else
   assign trap = 1'b0;
`endif

   // prod_q holds {accumulator/remainder, multiplier/quotient} during RUN
   always_comb begin
      a_mag     = a_q[31] ? (~a_q + 32'd1) : a_q;
      b_mag     = b_q[31] ? (~b_q + 32'd1) : b_q;
      sum_d     = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
      shifted_d = {prod_q[63:32], prod_q[31]};
      ge_d      = (shifted_d >= {1'b0, mcand_q});
      diff_d    = shifted_d[31:0] - mcand_q;
      prod_d    = op_q ? {(ge_d ? diff_d : shifted_d[31:0]), prod_q[30:0], ge_d}
                       : {sum_d, prod_q[31:1]};
      sign_res  = a_q[31] ^ b_q[31];
      prod_neg  = ~prod_q + 64'd1;
      q_neg     = ~prod_q[31:0] + 32'd1;
      r_neg     = ~prod_q[63:32] + 32'd1;
      if (op_q) begin
         fix_lo = sign_res ? q_neg : prod_q[31:0];
         fix_hi = a_q[31] ? r_neg : prod_q[63:32];
      end else begin
         fix_lo = sign_res ? prod_neg[31:0]  : prod_q[31:0];
         fix_hi = sign_res ? prod_neg[63:32] : prod_q[63:32];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= 1'b0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         mcand_q <= 32'd0;
         prod_q  <= 64'd0;
         cnt_q   <= 5'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         done_q <= 1'b0;
         dz_q   <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  a_q  <= a;
                  b_q  <= b;
                  op_q <= op;
                  if (trap) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     dz_q    <= 1'b1;
                  end else begin
                     state_q <= S_PREP;
                     busy_q  <= 1'b1;
                  end
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_PREP: begin
               mcand_q <= op_q ? b_mag : a_mag;
               prod_q  <= {32'd0, (op_q ? a_mag : b_mag)};
               cnt_q   <= 5'd0;
               state_q <= S_RUN;
            end
            S_RUN: begin
               prod_q <= prod_d;
               cnt_q  <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  state_q <= S_FIX;
               end
            end
            S_FIX: begin
               hi_q    <= fix_hi;
               lo_q    <= fix_lo;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign hi       = hi_q;
   assign lo       = lo_q;
   assign div_zero = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_ctrl
// Purpose  : Scoreboard bench for mult_div_ctrl (honours MULT_DIV_DIVZERO_TRAP_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        op    = 1'b0;
   logic [31:0] a     = 32'd0;
   logic [31:0] b     = 32'd0;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   exp_t        scb[$];
   logic [31:0] sh_hi = 32'd0;
   logic [31:0] sh_lo = 32'd0;
   int          n_chk = 0;
   int          n_pass = 0;
   int          ecnt = 0;

`ifdef MULT_DIV_DIVZERO_TRAP_EN
   localparam int DZ_LAT = 0;
`else
   localparam int DZ_LAT = 34;
`endif

   mult_div_ctrl dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo),
      .div_zero (div_zero)
   );

   always #5 clock = ~clock;
   always @(posedge clock) ecnt <= ecnt + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic exp_t model(input logic o, input logic [31:0] aa, input logic [31:0] bb);
      exp_t               e;
      logic signed [31:0] x, y;
      logic signed [63:0] pa, pb, p;
      e.dz = 1'b0;
      x = aa;
      y = bb;
      pa = x;
      pb = y;
      if (!o) begin
         p = pa * pb;
         e.hi = p[63:32];
         e.lo = p[31:0];
      end else if (bb == 32'd0) begin
`ifdef MULT_DIV_DIVZERO_TRAP_EN
         e.dz = 1'b1;
         e.hi = sh_hi;
         e.lo = sh_lo;
`else
         e.hi = aa;
         e.lo = aa[31] ? 32'h00000001 : 32'hFFFFFFFF;
`endif
      end else if (aa == 32'h80000000 && bb == 32'hFFFFFFFF) begin
         e.hi = 32'd0;
         e.lo = 32'h80000000;
      end else begin
         e.lo = x / y;
         e.hi = x % y;
      end
      sh_hi = e.hi;
      sh_lo = e.lo;
      return e;
   endfunction

   // Every done pulse must retire the oldest outstanding expectation
   always begin : mon
      exp_t e;
      @(posedge clock);
      #1;
      if (done) begin
         if (scb.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
         end else begin
            e = scb.pop_front();
            check("hi", hi, e.hi);
            check("lo", lo, e.lo);
            check("div_zero", 32'(div_zero), 32'(e.dz));
         end
      end
   end

   task automatic do_op(input logic o, input logic [31:0] aa, input logic [31:0] bb,
                        input int lat, input int pulse_at);
      int n, t0, nb;
      @(posedge clock); #1;
      start = 1'b1; op = o; a = aa; b = bb;
      scb.push_back(model(o, aa, bb));
      @(posedge clock); #1;
      t0 = ecnt;
      start = 1'b0; op = ~o; a = ~aa; b = bb + 32'd1;
      n  = 0;
      nb = busy ? 1 : 0;
      while (!done && n < 100) begin
         start = (n + 1 == pulse_at);
         if (start) begin
            a = 32'd100; b = 32'd100; op = 1'b1;
         end
         @(posedge clock); #1;
         n++;
         if (busy) nb++;
      end
      start = 1'b0;
      check("done_seen", 32'(done), 32'd1);
      check("latency", ecnt - t0, lat);
      check("busy_cycles", nb, lat);
   endtask

   initial begin : main
      int          t0, n, nd, d1, d2;
      logic [31:0] ra, rb;

      #1 reset = 1'b1;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_dz", 32'(div_zero), 32'd0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      do_op(1'b0, 32'd7, 32'hFFFFFFFD, 34, -1);
      check("mul_hi", hi, 32'hFFFFFFFF);
      check("mul_lo", lo, 32'hFFFFFFEB);
      do_op(1'b1, 32'hFFFFFFF9, 32'd2, 34, -1);
      check("div_q", lo, 32'hFFFFFFFD);
      do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 34, -1);
      check("ovf_q", lo, 32'h80000000);

      do_op(1'b0, 32'h66666666, 32'h2AAAAAAB, 34, -1);
      check("preload_hi", hi, 32'h11111111);
      check("preload_lo", lo, 32'h22222222);
      do_op(1'b1, 32'd5, 32'd0, DZ_LAT, -1);

      do_op(1'b0, 32'd3, 32'd4, 34, 10);
      check("ign_lo", lo, 32'd12);

      // Reset in the middle of a multiply
      @(posedge clock); #1;
      start = 1'b1; op = 1'b0; a = 32'h12345; b = 32'h6789;
      scb.push_back(model(1'b0, 32'h12345, 32'h6789));
      @(posedge clock); #1;
      start = 1'b0;
      repeat (20) @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      scb.delete();
      sh_hi = 32'd0;
      sh_lo = 32'd0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      repeat (40) @(posedge clock);
      do_op(1'b0, 32'd2, 32'd2, 34, -1);

      // Start held high through DONE: two operations back to back
      @(posedge clock); #1;
      start = 1'b1; op = 1'b0; a = 32'hFFFF0000; b = 32'h00010001;
      scb.push_back(model(1'b0, 32'hFFFF0000, 32'h00010001));
      @(posedge clock); #1;
      t0 = ecnt;
      op = 1'b1; a = 32'h7FFFFFFF; b = 32'h00000010;
      scb.push_back(model(1'b1, 32'h7FFFFFFF, 32'h00000010));
      n = 0; nd = 0; d1 = 0; d2 = 0;
      while (nd < 2 && n < 150) begin
         @(posedge clock); #1;
         n++;
         if (done) begin
            nd++;
            if (nd == 1) d1 = ecnt;
            else begin
               d2 = ecnt;
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      check("b2b_dones", nd, 2);
      check("b2b_first", d1 - t0, 34);
      check("b2b_gap", d2 - d1, 35);

      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i == 2) rb = 32'hFFFFFFF0;
         if (rb == 32'd0) rb = 32'd1;
         do_op(i[0], ra, rb, 34, -1);
      end

      repeat (3) @(posedge clock);
      #1;
      check("scb_empty", scb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
